digi_ota_bank: RTL and testbench
================================

Name: digi_ota_bank

Overview:
- Multi-channel, clocked successor to the gate-level digital OTA cell.
- Each channel compares a digital Vip/Vin pin pair and drives its output high (Vip wins) or low (Vin wins), or releases it to high-Z.
- Adds input synchronisers, qualification filtering, glitch-free direction change, optional hold-on-tie with timeout, and per-channel enables.
- Sits between the tile's input pins and the shared output/OE pads.

Parameters:
- NCH, 4, number of independent comparator channels.
- SYNC_STAGES, 2, synchroniser flops per input bit (minimum 2).
- CNT_W, 4, width of the qualification counter and qual_len.
- HOLD_W, 8, width of the hold timer and hold_max.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- vip  in  NCH  per-channel positive input (asynchronous).
- vin  in  NCH  per-channel negative input (asynchronous).
- ch_en  in  NCH  per-channel enable; 0 forces the channel to IDLE.
- mode_hold  in  1  0 = release on tie; 1 = hold the last decision on tie.
- qual_len  in  CNT_W  consecutive agreeing samples required to commit a direction; 0 is treated as 1.
- hold_max  in  HOLD_W  hold timeout in cycles; 0 = hold indefinitely.
- out  out  NCH  driven level (1 = Vip won, 0 = Vin won).
- out_oe  out  NCH  output enable (1 = drive, 0 = high-Z).
- evt  out  NCH  one-cycle pulse when a direction commits.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: all state is IDLE; out=0, out_oe=0, evt=0; synchroniser flops=0; counters=0.
- Synchroniser: vip and vin each pass through SYNC_STAGES flops. The synced sample s classifies as:
  - P when vp=1, vn=0
  - N when vp=0, vn=1
  - E (tie) when vp=vn
- Per-channel FSM: IDLE, QUAL, DRIVE, HOLD. Registers: dir (committed direction), cand (candidate direction), cnt (CNT_W bits), tmr (HOLD_W bits).
- IDLE (oe=0):
  - s in {P,N}: if Q=1, commit directly to DRIVE; else go to QUAL with cand=s, cnt=1.
  - s = E: stay in IDLE.
- QUAL:
  - s==cand: increment cnt; when the Q-th consecutive sample arrives, go to DRIVE with dir=cand and pulse evt.
  - s is the opposite direction: restart with cand=s, cnt=1.
  - s = E: return to IDLE if entered from IDLE; if entered from DRIVE/HOLD, go to HOLD when mode_hold=1, else IDLE.
  - Output: if QUAL was entered from DRIVE or HOLD, out/oe keep the old dir (make-before-break, no high-Z gap); if from IDLE, oe=0.
- DRIVE (oe=1, out=dir):
  - s==dir: stay.
  - s opposite: go to QUAL (cand=s, cnt=1), output unchanged.
  - s = E: mode_hold=0 goes to IDLE (oe=0 after that edge); mode_hold=1 goes to HOLD with tmr=1.
- HOLD (oe=1, out=dir):
  - s==dir: back to DRIVE, no evt.
  - s opposite: go to QUAL (output unchanged).
  - s = E: increment tmr; when hold_max≠0 and tmr==hold_max, go to IDLE.
  - tmr saturates at all-ones.
- Commit semantics:
  - evt pulses only on commit: IDLE→DRIVE, or QUAL→DRIVE.
  - A re-commit to the same dir still pulses evt; out is unchanged in that case.
- Latency: from IDLE, with an input pair stable before edge 0, out_oe and evt are registered at edge SYNC_STAGES+Q.
- ch_en=0: next edge forces IDLE, oe=0, evt=0, counters cleared; synchroniser keeps running. Re-enabling starts qualification from IDLE.
- qual_len, hold_max, mode_hold are sampled live every cycle:
  - If a change makes cnt≥Q, commit on the next matching sample.
  - mode_hold 1→0 while in HOLD: go to IDLE on the next E sample.
- rst mid-operation: everything returns to reset values at that edge, regardless of state. Channels are fully independent.

Test Plan:
- Reset/IDLE: rst high 3 cycles with vip=vin=1 → out=0, out_oe=0, evt=0 throughout; stays IDLE after release.
- Qualification latency: ch0 vip=1, vin=0 from cycle 0, qual_len=3 → out_oe[0]=1, out[0]=1, evt[0] pulse exactly at edge 5. A 2-cycle glitch with qual_len=3 → no commit.
- Glitch-free reversal: ch1 driving high, switch to vip=0, vin=1, qual_len=4 → out_oe[1] stays 1 continuously; out[1] changes 1→0 at edge SYNC+4 with a single evt.
- Tie handling:
  - mode_hold=0, tie after DRIVE → oe drops SYNC_STAGES+1 edges after the tie.
  - mode_hold=1, hold_max=5 → oe stays 1 for 5 tie samples, then drops.
  - hold_max=0 → never drops over 300 cycles.
- Enable/reset mid-op: ch_en[2]=0 during QUAL → channel 2 goes IDLE next edge, other channels unaffected. rst asserted during DRIVE → all outputs 0 the following edge.
- Boundary: qual_len=0 behaves as 1 (commit at edge SYNC+1); tmr saturates with hold_max=0 and HOLD_W=4.

Source files
------------

// File: rtl/digi_ota_bank.sv
// digi_ota_bank: bank of independent clocked comparator channels.
// Each channel synchronises a Vip/Vin pin pair, qualifies the winning
// direction over qual_len consecutive samples and drives out/out_oe,
// keeping the pad driven across a direction change and optionally
// holding the last decision while the inputs tie.
module digi_ota_bank #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int HOLD_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    vip,
    input  logic [NCH-1:0]    vin,
    input  logic [NCH-1:0]    ch_en,
    input  logic              mode_hold,
    input  logic [CNT_W-1:0]  qual_len,
    input  logic [HOLD_W-1:0] hold_max,
    output logic [NCH-1:0]    out,
    output logic [NCH-1:0]    out_oe,
    output logic [NCH-1:0]    evt
);

    typedef enum logic [1:0] {IDLE, QUAL, DRIVE, HOLD} state_t;

    // A qual_len of zero behaves exactly like one.
    logic [CNT_W-1:0] q_eff;
    assign q_eff = (qual_len == '0) ? CNT_W'(1) : qual_len;

    // Hold timer increment that sticks at all-ones instead of wrapping.
    function automatic logic [HOLD_W-1:0] tmr_sat_inc(input logic [HOLD_W-1:0] t);
        return (t == '1) ? t : t + HOLD_W'(1);
    endfunction

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] vp_sync, vn_sync;
        logic                   vp, vn, s_tie, s_dir;
        state_t                 state, state_nxt;
        logic                   dir, dir_nxt, cand, cand_nxt;
        logic                   from_act, from_act_nxt;
        logic [CNT_W-1:0]       cnt, cnt_nxt;
        logic [CNT_W:0]         cnt_inc;
        logic [HOLD_W-1:0]      tmr, tmr_nxt;
        logic                   out_q, oe_q, evt_q;
        logic                   out_nxt, oe_nxt, evt_nxt;

        assign vp      = vp_sync[SYNC_STAGES-1];
        assign vn      = vn_sync[SYNC_STAGES-1];
        assign s_tie   = (vp == vn);
        assign s_dir   = vp;
        assign cnt_inc = (CNT_W+1)'(cnt) + (CNT_W+1)'(1);

        // Input synchronisers; they keep running while the channel is disabled.
        always_ff @(posedge clk) begin
            if (rst) begin
                vp_sync <= '0;
                vn_sync <= '0;
            end else begin
                vp_sync <= {vp_sync[SYNC_STAGES-2:0], vip[i]};
                vn_sync <= {vn_sync[SYNC_STAGES-2:0], vin[i]};
            end
        end

        // Channel state and registered pad outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= IDLE;
                dir      <= 1'b0;
                cand     <= 1'b0;
                from_act <= 1'b0;
                cnt      <= '0;
                tmr      <= '0;
                out_q    <= 1'b0;
                oe_q     <= 1'b0;
                evt_q    <= 1'b0;
            end else begin
                state    <= state_nxt;
                dir      <= dir_nxt;
                cand     <= cand_nxt;
                from_act <= from_act_nxt;
                cnt      <= cnt_nxt;
                tmr      <= tmr_nxt;
                out_q    <= out_nxt;
                oe_q     <= oe_nxt;
                evt_q    <= evt_nxt;
            end
        end

        // Next-state decode; outputs follow the next state so they change on the commit edge.
        always_comb begin
            state_nxt    = state;
            dir_nxt      = dir;
            cand_nxt     = cand;
            from_act_nxt = from_act;
            cnt_nxt      = cnt;
            tmr_nxt      = tmr;
            evt_nxt      = 1'b0;
            if (!ch_en[i]) begin
                state_nxt    = IDLE;
                from_act_nxt = 1'b0;
                cnt_nxt      = '0;
                tmr_nxt      = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!s_tie) begin
                            if (q_eff == CNT_W'(1)) begin
                                state_nxt = DRIVE;
                                dir_nxt   = s_dir;
                                evt_nxt   = 1'b1;
                                cnt_nxt   = '0;
                            end else begin
                                state_nxt    = QUAL;
                                cand_nxt     = s_dir;
                                cnt_nxt      = CNT_W'(1);
                                from_act_nxt = 1'b0;
                            end
                        end
                    end
                    QUAL: begin
                        if (s_tie) begin
                            cnt_nxt = '0;
                            if (from_act && mode_hold) begin
                                state_nxt = HOLD;
                                tmr_nxt   = HOLD_W'(1);
                            end else begin
                                state_nxt    = IDLE;
                                from_act_nxt = 1'b0;
                            end
                        end else if (s_dir == cand) begin
                            // >= so that lowering qual_len live commits on the next match
                            if (cnt_inc >= {1'b0, q_eff}) begin
                                state_nxt    = DRIVE;
                                dir_nxt      = cand;
                                evt_nxt      = 1'b1;
                                cnt_nxt      = '0;
                                from_act_nxt = 1'b0;
                            end else begin
                                cnt_nxt = cnt_inc[CNT_W-1:0];
                            end
                        end else begin
                            cand_nxt = s_dir;
                            cnt_nxt  = CNT_W'(1);
                        end
                    end
                    DRIVE: begin
                        if (s_tie) begin
                            if (mode_hold) begin
                                state_nxt = HOLD;
                                tmr_nxt   = HOLD_W'(1);
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else if (s_dir != dir) begin
                            state_nxt    = QUAL;
                            cand_nxt     = s_dir;
                            cnt_nxt      = CNT_W'(1);
                            from_act_nxt = 1'b1;
                        end
                    end
                    HOLD: begin
                        if (s_tie) begin
                            if (!mode_hold || (hold_max != '0 && tmr >= hold_max)) begin
                                state_nxt = IDLE;
                                tmr_nxt   = '0;
                            end else begin
                                tmr_nxt = tmr_sat_inc(tmr);
                            end
                        end else if (s_dir == dir) begin
                            state_nxt = DRIVE;
                            tmr_nxt   = '0;
                        end else begin
                            state_nxt    = QUAL;
                            cand_nxt     = s_dir;
                            cnt_nxt      = CNT_W'(1);
                            from_act_nxt = 1'b1;
                            tmr_nxt      = '0;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
            // QUAL entered from an active state keeps the old level on the pad.
            oe_nxt  = (state_nxt == DRIVE) || (state_nxt == HOLD) ||
                      ((state_nxt == QUAL) && from_act_nxt);
            out_nxt = oe_nxt & dir_nxt;
        end

        assign out[i]    = out_q;
        assign out_oe[i] = oe_q;
        assign evt[i]    = evt_q;
    end

endmodule

// File: tb/tb_digi_ota_bank.sv
// Directed testbench for digi_ota_bank (default parameters plus a
// HOLD_W=4 instance for the hold-timer saturation case).
module tb_digi_ota_bank;

    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vip, vin, ch_en;
    logic       mode_hold;
    logic [3:0] qual_len;
    logic [7:0] hold_max;
    logic [3:0] out, out_oe, evt;

    logic [3:0] vip4, vin4;
    logic [3:0] hold_max4;
    logic [3:0] out4, out_oe4, evt4;

    int checks   = 0;
    int failures = 0;

    digi_ota_bank #(.NCH(4), .SYNC_STAGES(2), .CNT_W(4), .HOLD_W(8)) dut (
        .clk(clk), .rst(rst), .vip(vip), .vin(vin), .ch_en(ch_en),
        .mode_hold(mode_hold), .qual_len(qual_len), .hold_max(hold_max),
        .out(out), .out_oe(out_oe), .evt(evt)
    );

    digi_ota_bank #(.NCH(4), .SYNC_STAGES(2), .CNT_W(4), .HOLD_W(4)) dut4 (
        .clk(clk), .rst(rst), .vip(vip4), .vin(vin4), .ch_en(ch_en),
        .mode_hold(mode_hold), .qual_len(qual_len), .hold_max(hold_max4),
        .out(out4), .out_oe(out_oe4), .evt(evt4)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; sample and drive 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; vip = '0; vin = '0; vip4 = '0; vin4 = '0; ch_en = '1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; vip = '1; vin = '1; vip4 = '1; vin4 = '1; ch_en = '1;
        mode_hold = 1'b0; qual_len = 4'd3; hold_max = 8'd0; hold_max4 = 4'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({out, out_oe, evt} !== 12'h000) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got out=%b oe=%b evt=%b want all 0", c, out, out_oe, evt);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({out, out_oe, evt} !== 12'h000) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got out=%b oe=%b evt=%b want all 0", c, out, out_oe, evt);
            end
        end
    endtask

    task automatic test_qual_latency();
        apply_reset();
        qual_len = 4'd3; mode_hold = 1'b0;
        vip[0] = 1'b1; vin[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (out_oe !== ((e >= 5) ? 4'b0001 : 4'b0000) || out !== ((e >= 5) ? 4'b0001 : 4'b0000) ||
                evt !== ((e == 5) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL qual_latency edge=%0d got oe=%b out=%b evt=%b", e, out_oe, out, evt);
            end
        end
        // Two-sample glitch must not commit with qual_len=3.
        apply_reset();
        vip[0] = 1'b1; vin[0] = 1'b0;
        tick(); tick();
        vip[0] = 1'b0;
        for (int e = 3; e <= 10; e++) begin
            tick();
            checks++;
            if (out_oe !== 4'b0000 || evt !== 4'b0000) begin
                failures++;
                $display("FAIL glitch edge=%0d got oe=%b evt=%b want 0", e, out_oe, evt);
            end
        end
    endtask

    task automatic test_reversal();
        int npulse;
        apply_reset();
        qual_len = 4'd4; mode_hold = 1'b0;
        vip[1] = 1'b1; vin[1] = 1'b0;
        repeat (8) tick();
        checks++;
        if (out_oe[1] !== 1'b1 || out[1] !== 1'b1) begin
            failures++;
            $display("FAIL reversal_setup got oe=%b out=%b want oe1=1 out1=1", out_oe, out);
        end
        vip[1] = 1'b0; vin[1] = 1'b1;
        npulse = 0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (evt[1] === 1'b1) npulse++;
            checks++;
            if (out_oe[1] !== 1'b1 || out[1] !== ((e >= 6) ? 1'b0 : 1'b1) || evt[1] !== (e == 6)) begin
                failures++;
                $display("FAIL reversal edge=%0d got oe1=%b out1=%b evt1=%b", e, out_oe[1], out[1], evt[1]);
            end
        end
        checks++;
        if (npulse != 1) begin
            failures++;
            $display("FAIL reversal_evt_count got %0d want 1", npulse);
        end
    endtask

    task automatic test_tie_release();
        apply_reset();
        qual_len = 4'd1; mode_hold = 1'b0;
        vip[0] = 1'b1; vin[0] = 1'b0;
        repeat (4) tick();
        vin[0] = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if (out_oe[0] !== (e < 3)) begin
                failures++;
                $display("FAIL tie_release edge=%0d got oe0=%b want %b", e, out_oe[0], (e < 3));
            end
        end
    endtask

    task automatic test_tie_hold();
        bit dropped;
        bit pulsed;
        apply_reset();
        qual_len = 4'd1; mode_hold = 1'b1; hold_max = 8'd5;
        vip[0] = 1'b1; vin[0] = 1'b0;
        repeat (4) tick();
        vin[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (out_oe[0] !== (e < 8) || evt[0] !== 1'b0) begin
                failures++;
                $display("FAIL tie_hold5 edge=%0d got oe0=%b evt0=%b want oe0=%b", e, out_oe[0], evt[0], (e < 8));
            end
        end
        // Indefinite hold, then a matching sample returns to DRIVE without evt.
        apply_reset();
        hold_max = 8'd0;
        vip[0] = 1'b1; vin[0] = 1'b0;
        repeat (4) tick();
        vin[0] = 1'b1;
        dropped = 1'b0;
        for (int e = 1; e <= 300; e++) begin
            tick();
            if (out_oe[0] !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped) begin
            failures++;
            $display("FAIL hold_forever got oe0 drop=1 want 0");
        end
        vin[0] = 1'b0;
        pulsed = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (evt[0] !== 1'b0) pulsed = 1'b1;
        end
        checks++;
        if (pulsed || out_oe[0] !== 1'b1 || out[0] !== 1'b1) begin
            failures++;
            $display("FAIL hold_to_drive got evt_seen=%b oe0=%b out0=%b want 0,1,1", pulsed, out_oe[0], out[0]);
        end
        // mode_hold dropped while holding: leave on the next tie sample.
        vin[0] = 1'b1;
        repeat (4) tick();
        mode_hold = 1'b0;
        tick();
        checks++;
        if (out_oe[0] !== 1'b0) begin
            failures++;
            $display("FAIL hold_mode_off got oe0=%b want 0", out_oe[0]);
        end
    endtask

    task automatic test_enable_rst();
        apply_reset();
        qual_len = 4'd4; mode_hold = 1'b0;
        vip = 4'b1111; vin = 4'b0000;
        repeat (4) tick();
        ch_en[2] = 1'b0;
        tick();
        checks++;
        if (out_oe !== 4'b0000 || evt !== 4'b0000) begin
            failures++;
            $display("FAIL en_off_qual got oe=%b evt=%b want 0000", out_oe, evt);
        end
        tick();
        checks++;
        if (out_oe !== 4'b1011 || out !== 4'b1011 || evt !== 4'b1011) begin
            failures++;
            $display("FAIL en_others got oe=%b out=%b evt=%b want 1011", out_oe, out, evt);
        end
        ch_en[2] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (out_oe[2] !== (e >= 4) || evt[2] !== (e == 4) || out_oe[0] !== 1'b1) begin
                failures++;
                $display("FAIL en_requal edge=%0d got oe=%b evt=%b", e, out_oe, evt);
            end
        end
        ch_en[3] = 1'b0;
        tick();
        checks++;
        if (out_oe !== 4'b0111 || out !== 4'b0111) begin
            failures++;
            $display("FAIL en_off_drive got oe=%b out=%b want 0111", out_oe, out);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({out, out_oe, evt} !== 12'h000) begin
            failures++;
            $display("FAIL rst_mid got out=%b oe=%b evt=%b want all 0", out, out_oe, evt);
        end
    endtask

    task automatic test_boundary();
        apply_reset();
        qual_len = 4'd0; mode_hold = 1'b0;
        vip[3] = 1'b1; vin[3] = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (out_oe[3] !== (e >= 3) || evt[3] !== (e == 3)) begin
                failures++;
                $display("FAIL qual_zero edge=%0d got oe3=%b evt3=%b", e, out_oe[3], evt[3]);
            end
        end
        // Lowering qual_len below the running count commits on the next match.
        apply_reset();
        qual_len = 4'd8;
        vip[0] = 1'b1; vin[0] = 1'b0;
        repeat (5) tick();
        qual_len = 4'd2;
        checks++;
        if (out_oe[0] !== 1'b0) begin
            failures++;
            $display("FAIL qual_live_pre got oe0=%b want 0", out_oe[0]);
        end
        tick();
        checks++;
        if (out_oe[0] !== 1'b1 || evt[0] !== 1'b1) begin
            failures++;
            $display("FAIL qual_live got oe0=%b evt0=%b want 1,1", out_oe[0], evt[0]);
        end
        // HOLD_W=4 timer saturates at 15 rather than wrapping.
        apply_reset();
        qual_len = 4'd1; mode_hold = 1'b1; hold_max4 = 4'd0;
        vip4[0] = 1'b1; vin4[0] = 1'b0;
        repeat (4) tick();
        vin4[0] = 1'b1;
        repeat (42) tick();
        checks++;
        if (out_oe4[0] !== 1'b1) begin
            failures++;
            $display("FAIL tmr_sat_hold got oe0=%b want 1", out_oe4[0]);
        end
        hold_max4 = 4'd15;
        tick();
        checks++;
        if (out_oe4[0] !== 1'b0) begin
            failures++;
            $display("FAIL tmr_sat got oe0=%b want 0", out_oe4[0]);
        end
    endtask

    initial begin
        test_reset();
        test_qual_latency();
        test_reversal();
        test_tie_release();
        test_tie_hold();
        test_enable_rst();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
